// File: rtl/pe_row_drain_pkg.sv
// Shared types and sizing helpers for the PE row drain block.
package pe_drain_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DRAIN   = 2'd3
    } state_e;

    localparam int DEF_ADDR_WIDTH = 3;
    localparam int DEF_DATA_WIDTH = 3;

    function automatic int word_w(int addrWidth = DEF_ADDR_WIDTH,
                                  int dataWidth = DEF_DATA_WIDTH);
        return addrWidth + dataWidth;
    endfunction

endpackage

// File: rtl/pe_row_drain_if.sv
// Valid/ready stream carrying drained PE words and their column index.
interface pe_drain_if #(
    parameter int W  = 6,
    parameter int IW = 2
);
    logic          valid;
    logic          ready;
    logic [W-1:0]  word;
    logic [IW-1:0] idx;

    modport master (output valid, word, idx, input ready);
    modport slave  (input valid, word, idx, output ready);
endinterface

// File: rtl/pe_row_drain_mux.sv
// Combinational ROW_LEN:1 word selector over a flattened PE row.
module pe_row_mux #(
    parameter int ROW_LEN = 4,
    parameter int W       = 6,
    parameter int IW      = 2
) (
    input  logic [ROW_LEN*W-1:0] row_i,
    input  logic [IW-1:0]        sel_i,
    output logic [W-1:0]         word_o
);

    always_comb begin
        word_o = '0;
        for (int k = 0; k < ROW_LEN; k++) begin
            if (int'(sel_i) == k) begin
                word_o = row_i[k*W +: W];
            end
        end
    end

endmodule

// File: rtl/pe_row_drain.sv
// Snapshots one PE row after a settle delay and drains it word-by-word over a valid/ready stream.
// Define PE_DRAIN_SNAKE_EN to add i_rev for reversed (snake-order) readout.
module pe_row_drain
    import pe_drain_pkg::*;
#(
    parameter int ROW_LEN       = 4,
    parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int SETTLE_CYCLES = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
`ifdef PE_DRAIN_SNAKE_EN
    input  logic i_rev,
`endif
    input  logic [ROW_LEN*word_w(ADDR_WIDTH, DATA_WIDTH)-1:0] i_PE_row,
    pe_drain_if.master out_if,
    output logic o_busy,
    output logic o_done,
    output logic o_overrun
);

    localparam int W  = word_w(ADDR_WIDTH, DATA_WIDTH);
    localparam int IW = $clog2(ROW_LEN);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [IW-1:0] LAST_COL = IW'(ROW_LEN - 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [ROW_LEN*W-1:0] snap_q, snap_d, muxRow;
    logic [IW-1:0]        idx_q, idx_d, nextIdx, firstIdx, lastIdx;
    logic [W-1:0]         word_q, word_d, muxWord;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 busy_q, busy_d;
    logic                 overrun_q, overrun_d;
    logic                 accept, isLast, isRev;

`ifdef PE_DRAIN_SNAKE_EN
    logic rev_q, rev_d;

    // Direction is latched with the start pulse and held for the whole drain.
    assign rev_d = (state_q == IDLE && i_start) ? i_rev : rev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rev_q <= 1'b0;
        else      rev_q <= rev_d;
    end

    assign isRev = rev_q;
`else
    assign isRev = 1'b0;
`endif

    assign accept   = valid_q && out_if.ready;
    assign firstIdx = isRev ? '0 : LAST_COL;
    assign lastIdx  = isRev ? '0 : LAST_COL;
    assign isLast   = (idx_q == lastIdx);

    // CAPTURE reads the live row so the first word is ready on the capture edge.
    assign nextIdx = (state_q == CAPTURE) ? (isRev ? LAST_COL : '0)
                   : (isRev ? idx_q - 1'b1 : idx_q + 1'b1);
    assign muxRow  = (state_q == CAPTURE) ? i_PE_row : snap_q;

    pe_row_mux #(
        .ROW_LEN (ROW_LEN),
        .W       (W),
        .IW      (IW)
    ) u_mux (
        .row_i  (muxRow),
        .sel_i  (nextIdx),
        .word_o (muxWord)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (i_start) state_d = SETTLE;
            SETTLE:  if (cnt_q == '0) state_d = CAPTURE;
            CAPTURE: state_d = DRAIN;
            DRAIN:   if (accept && isLast) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d     = cnt_q;
        snap_d    = snap_q;
        idx_d     = idx_q;
        word_d    = word_q;
        valid_d   = valid_q;
        done_d    = 1'b0;
        overrun_d = overrun_q | (i_start && state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (i_start) cnt_d = CW'(SETTLE_CYCLES - 1);
            end
            SETTLE: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
            end
            CAPTURE: begin
                snap_d  = i_PE_row;
                idx_d   = nextIdx;
                word_d  = muxWord;
                valid_d = 1'b1;
            end
            DRAIN: begin
                if (accept) begin
                    if (isLast) begin
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d  = nextIdx;
                        word_d = muxWord;
                    end
                end
            end
            default: ;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q     <= '0;
            snap_q    <= '0;
            idx_q     <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            snap_q    <= snap_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    assign out_if.valid = valid_q;
    assign out_if.word  = word_q;
    assign out_if.idx   = idx_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_overrun    = overrun_q;

endmodule

// File: tb/tb_pe_row_drain.sv
// Directed testbench for pe_row_drain (ROW_LEN=4, W=6, SETTLE_CYCLES=2).
module tb_pe_row_drain;

    localparam int ROW_LEN = 4;
    localparam int AW      = 3;
    localparam int DW      = 3;
    localparam int W       = 6;
    localparam int IW      = 2;
    localparam int SETTLE  = 2;
    localparam logic [ROW_LEN*W-1:0] BASE_ROW = {6'o43, 6'o12, 6'o70, 6'o05};

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 i_start;
    logic [ROW_LEN*W-1:0] row;
    logic                 busy, done, overrun;
`ifdef PE_DRAIN_SNAKE_EN
    logic                 rev;
`endif

    int errors = 0;
    int checks = 0;

    pe_drain_if #(.W(W), .IW(IW)) bus ();

    pe_row_drain #(
        .ROW_LEN       (ROW_LEN),
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
`ifdef PE_DRAIN_SNAKE_EN
        .i_rev     (rev),
`endif
        .i_PE_row  (row),
        .out_if    (bus),
        .o_busy    (busy),
        .o_done    (done),
        .o_overrun (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] colOf(logic [ROW_LEN*W-1:0] r, int k);
        return r[k*W +: W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startPulse();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    task automatic waitValid(input int budget, output bit ok);
        int n = 0;
        while (bus.valid !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        ok = (bus.valid === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_start = 1'b0;
        bus.ready = 1'b0;
        row = BASE_ROW;
`ifdef PE_DRAIN_SNAKE_EN
        rev = 1'b0;
`endif
        #1 rst = 1'b0;
        #2;
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", bus.valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (bus.word !== 6'o00) begin errors++; $display("[TB] FAIL reset_word: got %o want 0", bus.word); end
        checks++; if (bus.idx !== 2'd0) begin errors++; $display("[TB] FAIL reset_idx: got %0d want 0", bus.idx); end
        @(negedge clk);
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bus.ready = 1'b1;
        startPulse();
        tick();
        tick();
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_latency_early: valid got %b want 0", bus.valid); end
        checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL basic_busy_settle: got %b want 1", busy); end
        tick();
        for (int i = 0; i < ROW_LEN; i++) begin
            checks++; if (bus.valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_valid[%0d]: got %b want 1", i, bus.valid); end
            checks++; if (bus.word !== colOf(BASE_ROW, i)) begin errors++; $display("[TB] FAIL basic_word[%0d]: got %o want %o", i, bus.word, colOf(BASE_ROW, i)); end
            checks++; if (bus.idx !== IW'(i)) begin errors++; $display("[TB] FAIL basic_idx[%0d]: got %0d want %0d", i, bus.idx, i); end
            checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_early[%0d]: got %b want 0", i, done); end
            tick();
        end
        checks++; if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_end: got %b want 0", bus.valid); end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL basic_done: got %b want 1", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL basic_busy_end: got %b want 0", busy); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL basic_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_backpressure();
        bit ok;
        bus.ready = 1'b1;
        startPulse();
        waitValid(10, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL bp_timeout: valid got %b want 1", bus.valid); end
        checks++; if (bus.idx !== 2'd0) begin errors++; $display("[TB] FAIL bp_idx0: got %0d want 0", bus.idx); end
        tick();
        checks++; if (bus.word !== 6'o70 || bus.idx !== 2'd1) begin errors++; $display("[TB] FAIL bp_first_idx1: got %o/%0d want 70/1", bus.word, bus.idx); end
        bus.ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            tick();
            checks++; if (bus.valid !== 1'b1 || bus.word !== 6'o70 || bus.idx !== 2'd1) begin
                errors++; $display("[TB] FAIL bp_hold[%0d]: got v=%b %o/%0d want v=1 70/1", j, bus.valid, bus.word, bus.idx);
            end
        end
        bus.ready = 1'b1;
        tick();
        checks++; if (bus.word !== 6'o12 || bus.idx !== 2'd2) begin errors++; $display("[TB] FAIL bp_idx2: got %o/%0d want 12/2", bus.word, bus.idx); end
        tick();
        checks++; if (bus.word !== 6'o43 || bus.idx !== 2'd3) begin errors++; $display("[TB] FAIL bp_idx3: got %o/%0d want 43/3", bus.word, bus.idx); end
        tick();
        checks++; if (done !== 1'b1 || bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL bp_done: got done=%b valid=%b want 1/0", done, bus.valid); end
        tick();
    endtask

    task automatic test_snapshot();
        bit ok;
        bus.ready = 1'b1;
        startPulse();
        waitValid(10, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL snap_timeout: valid got %b want 1", bus.valid); end
        row = {ROW_LEN*W{1'b1}};
        for (int i = 0; i < ROW_LEN; i++) begin
            checks++; if (bus.word !== colOf(BASE_ROW, i) || bus.idx !== IW'(i)) begin
                errors++; $display("[TB] FAIL snap_word[%0d]: got %o/%0d want %o/%0d", i, bus.word, bus.idx, colOf(BASE_ROW, i), i);
            end
            tick();
        end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL snap_done: got %b want 1", done); end
        row = BASE_ROW;
        tick();
    endtask

    task automatic test_overrun();
        bit ok;
        bus.ready = 1'b1;
        startPulse();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        checks++; if (overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_settle: got %b want 1", overrun); end
        waitValid(10, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL ovr_timeout: valid got %b want 1", bus.valid); end
        checks++; if (bus.word !== 6'o05 || bus.idx !== 2'd0) begin errors++; $display("[TB] FAIL ovr_idx0: got %o/%0d want 05/0", bus.word, bus.idx); end
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int i = 1; i < ROW_LEN; i++) begin
            checks++; if (bus.word !== colOf(BASE_ROW, i) || bus.idx !== IW'(i)) begin
                errors++; $display("[TB] FAIL ovr_word[%0d]: got %o/%0d want %o/%0d", i, bus.word, bus.idx, colOf(BASE_ROW, i), i);
            end
            tick();
        end
        checks++; if (done !== 1'b1 || overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_done: got done=%b ovr=%b want 1/1", done, overrun); end
        tick();
        startPulse();
        waitValid(10, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL ovr_restart_timeout: valid got %b want 1", bus.valid); end
        for (int i = 0; i < ROW_LEN; i++) begin
            checks++; if (bus.word !== colOf(BASE_ROW, i) || bus.idx !== IW'(i)) begin
                errors++; $display("[TB] FAIL ovr_restart_word[%0d]: got %o/%0d want %o/%0d", i, bus.word, bus.idx, colOf(BASE_ROW, i), i);
            end
            tick();
        end
        checks++; if (done !== 1'b1 || overrun !== 1'b1) begin errors++; $display("[TB] FAIL ovr_restart_done: got done=%b ovr=%b want 1/1", done, overrun); end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        bit ok;
        bus.ready = 1'b1;
        startPulse();
        waitValid(10, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rmid_timeout: valid got %b want 1", bus.valid); end
        tick();
        tick();
        checks++; if (bus.idx !== 2'd2) begin errors++; $display("[TB] FAIL rmid_pre_idx: got %0d want 2", bus.idx); end
        #2 rst = 1'b0;
        #1;
        checks++; if (bus.valid !== 1'b0 || busy !== 1'b0 || bus.idx !== 2'd0) begin
            errors++; $display("[TB] FAIL rmid_async: got v=%b busy=%b idx=%0d want 0/0/0", bus.valid, busy, bus.idx);
        end
        checks++; if (done !== 1'b0 || overrun !== 1'b0) begin errors++; $display("[TB] FAIL rmid_flags: got done=%b ovr=%b want 0/0", done, overrun); end
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rmid_after: got done=%b busy=%b want 0/0", done, busy); end
        startPulse();
        waitValid(10, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL rmid_restart_timeout: valid got %b want 1", bus.valid); end
        for (int i = 0; i < ROW_LEN; i++) begin
            checks++; if (bus.word !== colOf(BASE_ROW, i) || bus.idx !== IW'(i)) begin
                errors++; $display("[TB] FAIL rmid_word[%0d]: got %o/%0d want %o/%0d", i, bus.word, bus.idx, colOf(BASE_ROW, i), i);
            end
            tick();
        end
        checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL rmid_done: got %b want 1", done); end
        tick();
    endtask

`ifdef PE_DRAIN_SNAKE_EN
    task automatic test_snake();
        bit ok;
        bus.ready = 1'b1;
        rev = 1'b1;
        startPulse();
        rev = 1'b0;
        waitValid(10, ok);
        checks++; if (!ok) begin errors++; $display("[TB] FAIL snake_timeout: valid got %b want 1", bus.valid); end
        for (int i = 0; i < ROW_LEN; i++) begin
            checks++; if (bus.word !== colOf(BASE_ROW, ROW_LEN-1-i) || bus.idx !== IW'(ROW_LEN-1-i)) begin
                errors++; $display("[TB] FAIL snake_word[%0d]: got %o/%0d want %o/%0d", i, bus.word, bus.idx, colOf(BASE_ROW, ROW_LEN-1-i), ROW_LEN-1-i);
            end
            checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL snake_done_early[%0d]: got %b want 0", i, done); end
            tick();
        end
        checks++; if (done !== 1'b1 || bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL snake_done: got done=%b valid=%b want 1/0", done, bus.valid); end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_snapshot();
        test_overrun();
        test_reset_mid_drain();
`ifdef PE_DRAIN_SNAKE_EN
        test_snake();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
